// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache and its fill controller.
package cache_pkg;

  // Tags are stored zero-extended to this width in the metadata struct.
  localparam int unsigned MaxTagW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StCommit
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [MaxTagW-1:0] tag;
  } line_meta_t;

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words) + 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                        input int unsigned words);
    return addr_w - off_w(words) - idx_w(sets);
  endfunction

endpackage

// File: rtl/cache_fill_ctrl.sv
// Miss FSM: pipelined block fill (one request per cycle, in-order returns) then a commit cycle.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic                     mem_rvalid,
  output state_e                   state,
  output logic                     fill_rd,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [ADDR_W-1:0]        base_addr,
  output logic                     fill_we,
  output logic [$clog2(WORDS)-1:0] rtn_cnt,
  output logic                     commit
);

  localparam int unsigned RtnW = $clog2(WORDS);
  localparam int unsigned IssW = RtnW + 1;

  state_e            state_q, state_d;
  logic [IssW-1:0]   issue_q, issue_d;
  logic [RtnW-1:0]   rtn_q, rtn_d;
  logic [ADDR_W-1:0] base_q, base_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      issue_q <= '0;
      rtn_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      rtn_q   <= rtn_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    rtn_d   = rtn_q;
    base_d  = base_q;
    fill_rd = 1'b0;
    fill_we = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          base_d  = start_addr;
          issue_d = '0;
          rtn_d   = '0;
        end
      end
      StFill: begin
        if (issue_q < IssW'(WORDS)) begin
          fill_rd = 1'b1;
          issue_d = issue_q + IssW'(1);
        end
        if (mem_rvalid) begin
          fill_we = 1'b1;
          rtn_d   = rtn_q + RtnW'(1);
          if (rtn_q == RtnW'(WORDS - 1)) state_d = StCommit;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign state     = state_q;
  assign base_addr = base_q;
  assign rtn_cnt   = rtn_q;
  assign fill_addr = base_q + ADDR_W'({issue_q, 1'b0});

endmodule

// File: rtl/set_assoc_cache.sv
// N-way (1 or 2) write-through, write-allocate cache with LRU and pipelined fill.
// Optional CACHE_STATS_EN adds saturating hit/miss counters.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SETS   = 128,
  parameter int unsigned WAYS   = 2,
  parameter int unsigned WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_rd,
  input  logic              pipe_wr,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned OffW = off_w(WORDS);
  localparam int unsigned IdxW = idx_w(SETS);
  localparam int unsigned TagW = tag_w(ADDR_W, SETS, WORDS);
  localparam int unsigned WrdW = $clog2(WORDS);

  line_meta_t        meta_q [WAYS][SETS];
  logic [SETS-1:0]   lru_q;
  logic [DATA_W-1:0] data_q [WAYS][SETS][WORDS];
  logic              victim_q;

  logic [TagW-1:0]   req_tag, fill_tag;
  logic [IdxW-1:0]   req_idx, fill_idx;
  logic [WrdW-1:0]   req_word, rtn_cnt;
  logic              req, hit, hit_way, victim, complete, start;
  logic              fill_rd, fill_we, commit;
  logic [ADDR_W-1:0] fill_addr, base_addr;
  state_e            state;

  assign req_tag  = pipe_addr[ADDR_W-1 -: TagW];
  assign req_idx  = pipe_addr[OffW +: IdxW];
  assign req_word = pipe_addr[OffW-1:1];
  assign fill_tag = base_addr[ADDR_W-1 -: TagW];
  assign fill_idx = base_addr[OffW +: IdxW];

  logic unused_bits;
  assign unused_bits = ^{pipe_addr[0], base_addr[OffW-1:0]};

  function automatic logic not_mru(input logic way);
    return (WAYS > 1) ? ~way : 1'b0;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (meta_q[w][req_idx].valid && meta_q[w][req_idx].tag == MaxTagW'(req_tag)) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
  end

  // Lowest-numbered invalid way wins; with all ways valid, the LRU pointer decides.
  always_comb begin
    victim = lru_q[req_idx];
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!meta_q[w][req_idx].valid) victim = w[0];
    end
  end

  assign req        = pipe_rd | pipe_wr;
  assign complete   = req && hit && (state == StIdle);
  assign start      = req && !hit && (state == StIdle);
  assign pipe_stall = req && !complete;
  assign mem_we     = complete && pipe_wr;
  assign mem_rd     = fill_rd;
  assign mem_wdata  = pipe_wdata;
  assign pipe_rdata = complete ? data_q[hit_way][req_idx][req_word] : '0;

  always_comb begin
    mem_addr = '0;
    if (fill_rd)     mem_addr = fill_addr;
    else if (mem_we) mem_addr = pipe_addr;
  end

  cache_fill_ctrl #(
    .ADDR_W(ADDR_W),
    .WORDS (WORDS)
  ) u_fill_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr({pipe_addr[ADDR_W-1:OffW], {OffW{1'b0}}}),
    .mem_rvalid(mem_rvalid),
    .state     (state),
    .fill_rd   (fill_rd),
    .fill_addr (fill_addr),
    .base_addr (base_addr),
    .fill_we   (fill_we),
    .rtn_cnt   (rtn_cnt),
    .commit    (commit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) meta_q[w][s] <= '0;
      end
      lru_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      if (start) victim_q <= victim;
      if (commit) begin
        meta_q[victim_q][fill_idx] <= line_meta_t'{valid: 1'b1, tag: MaxTagW'(fill_tag)};
        lru_q[fill_idx]            <= not_mru(victim_q);
      end else if (complete) begin
        lru_q[req_idx] <= not_mru(hit_way);
      end
    end
  end

  // Data array has no reset; valid bits guard every read of it.
  always_ff @(posedge clk) begin
    if (fill_we && !rst) begin
      data_q[victim_q][fill_idx][rtn_cnt] <= mem_rdata;
    end else if (mem_we && !rst) begin
      data_q[hit_way][req_idx][req_word] <= pipe_wdata;
    end
  end

`ifdef CACHE_STATS_EN
  logic after_fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      after_fill_q <= 1'b0;
    end else begin
      if (commit)        after_fill_q <= 1'b1;
      else if (complete) after_fill_q <= 1'b0;
      if (complete && !after_fill_q && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (start && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
